// File: rtl/sram_fifo_pkg.sv
// Shared helpers for the SRAM-backed FIFO controller: the pointer wrap rule
// and the width derivation for the occupancy counter.
package sram_fifo_pkg;

  // The occupancy counter must hold MEM_SZ SRAM entries plus the in-flight
  // read and the two output-buffer slots. Two extra bits cover that.
  localparam int unsigned CNT_PAD = 2;

  function automatic int unsigned cnt_sz(input int unsigned addr_sz);
    return addr_sz + CNT_PAD;
  endfunction

  // Advance a pointer by one entry. MEM_SZ need not be a power of two, so
  // the pointer wraps explicitly at MEM_SZ-1.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned mem_sz);
    return (ptr >= mem_sz - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sram_fifo_ctrl_fifo2_buf.sv
// Two-entry output buffer that absorbs the SRAM's one-cycle read latency.
// A push and a pop may occur in the same cycle, including when both slots
// are full: the pop frees the head slot and the push lands at the tail.
module fifo2_buf #(
  parameter int unsigned DATA_SZ = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [DATA_SZ-1:0] i_push_data,
  input  logic               i_pop,
  output logic [DATA_SZ-1:0] o_head,
  output logic [1:0]         o_cnt
);

  logic [DATA_SZ-1:0] r_slot0;
  logic [DATA_SZ-1:0] r_slot1;
  logic [1:0]         r_cnt;
  logic               w_pop;
  logic               w_push;
  logic [1:0]         w_fill;

  // A pop on an empty buffer, or a push into a full one without a pop, is ignored.
  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);
  // Occupancy after the pop: this is the slot index the push lands in.
  assign w_fill = r_cnt - {1'b0, w_pop};

  assign o_head = r_slot0;
  assign o_cnt  = r_cnt;

  // Occupancy counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
    end else begin
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Payload slots: shift on pop, then write the push into the first free slot.
  // NOTE: payload storage is deliberately not reset; r_cnt alone decides
  // validity, and leaving data flops unreset keeps them plain enable flops.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_slot0 <= r_slot1;
    end
    if (w_push) begin
      if (w_fill == 2'd0) begin
        r_slot0 <= i_push_data;
      end else begin
        r_slot1 <= i_push_data;
      end
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller in front of a 1R1W SRAM with registered read
// data. Reads are issued early into a two-entry output buffer so the FIFO
// sustains one enqueue and one dequeue per cycle.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int unsigned ADDR_SZ = 9,
  parameter int unsigned DATA_SZ = 64,
  parameter int unsigned MEM_SZ  = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enq_valid,
  output logic               o_enq_ready,
  input  logic [DATA_SZ-1:0] i_enq_data,
  output logic               o_deq_valid,
  input  logic               i_deq_ready,
  output logic [DATA_SZ-1:0] o_deq_data,
  output logic               o_sram_write_en,
  output logic [ADDR_SZ-1:0] o_sram_write_addr,
  output logic [DATA_SZ-1:0] o_sram_write_data,
  output logic               o_sram_read_en,
  output logic [ADDR_SZ-1:0] o_sram_read_addr,
  input  logic [DATA_SZ-1:0] i_sram_read_data,
  output logic [ADDR_SZ+1:0] o_count
);

  localparam int unsigned CNT_SZ  = cnt_sz(ADDR_SZ);
  localparam int unsigned SCNT_SZ = ADDR_SZ + 1;

  logic [ADDR_SZ-1:0] r_wr_ptr;
  logic [ADDR_SZ-1:0] r_rd_ptr;
  logic [SCNT_SZ-1:0] r_sram_cnt;
  logic               r_inflight;

  logic [1:0]         w_ob_cnt;
  logic [DATA_SZ-1:0] w_ob_head;
  logic               w_enq_fire;
  logic               w_deq_fire;
  logic               w_rd_issue;
  logic [2:0]         w_ob_demand;

  // Full only when the SRAM region is full; the output buffer is extra capacity.
  assign o_enq_ready = (r_sram_cnt < SCNT_SZ'(MEM_SZ));
  // rst_n gating keeps the SRAM ports quiet while reset is held, even if the
  // producer keeps enq_valid high.
  assign w_enq_fire  = i_enq_valid && o_enq_ready && rst_n;

  assign o_deq_valid = (w_ob_cnt != 2'd0);
  assign o_deq_data  = w_ob_head;
  assign w_deq_fire  = o_deq_valid && i_deq_ready;

  // Slots the buffer will need next cycle if no new read is issued. A read
  // is issued only when it is guaranteed a slot, so the buffer never overflows.
  assign w_ob_demand = {1'b0, w_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_deq_fire};
  assign w_rd_issue  = rst_n && (r_sram_cnt != '0) && (w_ob_demand < 3'd2);

  // An entry written this cycle is not counted in r_sram_cnt until the edge,
  // so a read can never target an address being written in the same cycle.
  assign o_sram_write_en   = w_enq_fire;
  assign o_sram_write_addr = r_wr_ptr;
  assign o_sram_write_data = i_enq_data;
  assign o_sram_read_en    = w_rd_issue;
  assign o_sram_read_addr  = r_rd_ptr;

  assign o_count = CNT_SZ'(r_sram_cnt) + CNT_SZ'(r_inflight) + CNT_SZ'(w_ob_cnt);

  // Pointer, SRAM occupancy and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sram_cnt <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_enq_fire) begin
        r_wr_ptr <= ADDR_SZ'(ptr_inc(32'(r_wr_ptr), MEM_SZ));
      end
      if (w_rd_issue) begin
        r_rd_ptr <= ADDR_SZ'(ptr_inc(32'(r_rd_ptr), MEM_SZ));
      end
      case ({w_enq_fire, w_rd_issue})
        2'b10:   r_sram_cnt <= r_sram_cnt + 1'b1;
        2'b01:   r_sram_cnt <= r_sram_cnt - 1'b1;
        default: r_sram_cnt <= r_sram_cnt;
      endcase
      // Clearing this on reset is what discards read data from a pre-reset read.
      r_inflight <= w_rd_issue;
    end
  end

  // Output buffer: catches read data the cycle after issue, presents the head.
  fifo2_buf #(
    .DATA_SZ(DATA_SZ)
  ) u_ob (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_inflight),
    .i_push_data(i_sram_read_data),
    .i_pop      (w_deq_fire),
    .o_head     (w_ob_head),
    .o_cnt      (w_ob_cnt)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 1R1W SRAM and a
// queue scoreboard of accepted payloads.
module tb_sram_fifo_ctrl;

  localparam int unsigned ADDR_SZ = 3;
  localparam int unsigned DATA_SZ = 64;
  localparam int unsigned MEM_SZ  = 5;

  logic               clk;
  logic               rst_n;
  logic               enq_valid;
  logic               enq_ready;
  logic [DATA_SZ-1:0] enq_data;
  logic               deq_valid;
  logic               deq_ready;
  logic [DATA_SZ-1:0] deq_data;
  logic               sram_write_en;
  logic [ADDR_SZ-1:0] sram_write_addr;
  logic [DATA_SZ-1:0] sram_write_data;
  logic               sram_read_en;
  logic [ADDR_SZ-1:0] sram_read_addr;
  logic [DATA_SZ-1:0] sram_read_data;
  logic [ADDR_SZ+1:0] count;

  sram_fifo_ctrl #(
    .ADDR_SZ(ADDR_SZ),
    .DATA_SZ(DATA_SZ),
    .MEM_SZ (MEM_SZ)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_enq_valid      (enq_valid),
    .o_enq_ready      (enq_ready),
    .i_enq_data       (enq_data),
    .o_deq_valid      (deq_valid),
    .i_deq_ready      (deq_ready),
    .o_deq_data       (deq_data),
    .o_sram_write_en  (sram_write_en),
    .o_sram_write_addr(sram_write_addr),
    .o_sram_write_data(sram_write_data),
    .o_sram_read_en   (sram_read_en),
    .o_sram_read_addr (sram_read_addr),
    .i_sram_read_data (sram_read_data),
    .o_count          (count)
  );

  // Behavioural SRAM: write at the edge, registered read data.
  logic [DATA_SZ-1:0] mem [0:(1<<ADDR_SZ)-1];
  always @(posedge clk) begin
    if (sram_write_en) mem[sram_write_addr] <= sram_write_data;
    if (sram_read_en)  sram_read_data <= mem[sram_read_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_SZ-1:0] exp_q[$];
  int                 cyc = 0;
  int                 m_wptr = 0;
  int                 m_rptr = 0;
  int                 n_deq = 0;
  int                 first_deq_cyc = 0;
  int                 last_deq_cyc = 0;
  logic               prev_stall = 1'b0;
  logic [DATA_SZ-1:0] prev_data = '0;

  // Values sampled #1 after the negedge, well away from the active edge.
  logic               s_ready, s_dvalid, s_wen, s_ren;
  logic [DATA_SZ-1:0] s_ddata, s_wdata;
  logic [ADDR_SZ-1:0] s_waddr, s_raddr;
  logic [ADDR_SZ+1:0] s_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample, score, then advance to the next negedge.
  task automatic step(input logic ev, input logic [DATA_SZ-1:0] ed, input logic dr);
    logic fire;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    #1;
    s_ready  = enq_ready;
    s_dvalid = deq_valid;
    s_ddata  = deq_data;
    s_wen    = sram_write_en;
    s_waddr  = sram_write_addr;
    s_wdata  = sram_write_data;
    s_ren    = sram_read_en;
    s_raddr  = sram_read_addr;
    s_count  = count;
    fire     = ev && s_ready;

    check("count", 64'(s_count), 64'(exp_q.size()));
    if (prev_stall) begin
      check("stall_valid", 64'(s_dvalid), 64'(1));
      check("stall_data", s_ddata, prev_data);
    end
    check("write_en", 64'(s_wen), 64'(fire));
    if (fire) begin
      check("write_addr", 64'(s_waddr), 64'(m_wptr));
      check("write_data", s_wdata, ed);
      m_wptr = (m_wptr + 1) % MEM_SZ;
    end
    if (s_ren) begin
      check("read_addr", 64'(s_raddr), 64'(m_rptr));
      m_rptr = (m_rptr + 1) % MEM_SZ;
    end
    if (s_dvalid && dr) begin
      check("deq_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("deq_data", s_ddata, exp_q.pop_front());
      if (n_deq == 0) first_deq_cyc = cyc;
      last_deq_cyc = cyc;
      n_deq++;
    end
    if (fire) exp_q.push_back(ed);
    prev_stall = s_dvalid && !dr;
    prev_data  = s_ddata;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    step(1'b0, '0, 1'b1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wptr     = 0;
    m_rptr     = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int acc;
    int sent;

    // Reset state, with enq_valid held high to show it cannot write.
    rst_n     = 1'b0;
    enq_valid = 1'b1;
    enq_data  = 64'hDEAD;
    deq_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_enq_ready", 64'(enq_ready), 64'(1));
    check("rst_deq_valid", 64'(deq_valid), 64'(0));
    check("rst_write_en", 64'(sram_write_en), 64'(0));
    check("rst_read_en", 64'(sram_read_en), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    enq_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1);

    // Single entry latency: enq c0, read c1, data c2, deq_valid c3.
    step(1'b1, 64'hA5, 1'b1);
    check("t1_write_addr", 64'(s_waddr), 64'(0));
    step(1'b0, '0, 1'b1);
    check("t1_read_en", 64'(s_ren), 64'(1));
    check("t1_read_addr", 64'(s_raddr), 64'(0));
    step(1'b0, '0, 1'b1);
    check("t1_c2_deq_valid", 64'(s_dvalid), 64'(0));
    step(1'b0, '0, 1'b1);
    check("t1_c3_deq_valid", 64'(s_dvalid), 64'(1));
    check("t1_c3_deq_data", s_ddata, 64'hA5);
    step(1'b0, '0, 1'b1);
    check("t1_c4_deq_valid", 64'(s_dvalid), 64'(0));

    // Streaming with pointer wrap: 20 back-to-back items, one deq per cycle.
    n_deq = 0;
    t0    = cyc;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 64'(i), 1'b1);
      check("stream_enq_ready", 64'(s_ready), 64'(1));
    end
    drain(30);
    check("stream_n_deq", 64'(n_deq), 64'(20));
    check("stream_first_lat", 64'(first_deq_cyc - t0), 64'(3));
    check("stream_span", 64'(last_deq_cyc - first_deq_cyc), 64'(19));

    // Fill with the consumer stalled: capacity is MEM_SZ + 2.
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 64'(100 + i), 1'b0);
      if (s_ready) acc++;
      if (i >= 7) check("full_no_write", 64'(s_wen), 64'(0));
    end
    check("fill_accepted", 64'(acc), 64'(7));
    step(1'b0, '0, 1'b0);
    check("full_enq_ready", 64'(s_ready), 64'(0));
    check("full_count", 64'(s_count), 64'(7));
    drain(20);

    // Alternating backpressure under continuous enqueue.
    sent = 0;
    for (int c = 0; c < 200 && sent < 30; c++) begin
      step(1'b1, 64'(200 + sent), (c % 2) == 0);
      if (s_ready) sent++;
    end
    check("toggle_sent", 64'(sent), 64'(30));
    drain(80);

    // Enq and deq in the same cycle with one item in the buffer, SRAM empty.
    step(1'b1, 64'h51, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check("same_c3_valid", 64'(s_dvalid), 64'(1));
    step(1'b1, 64'h52, 1'b1);
    check("same_c4_valid", 64'(s_dvalid), 64'(1));
    check("same_c4_count", 64'(s_count), 64'(1));
    step(1'b0, '0, 1'b0);
    check("same_c5_count", 64'(s_count), 64'(1));
    check("same_c5_valid", 64'(s_dvalid), 64'(0));
    step(1'b0, '0, 1'b0);
    check("same_c6_valid", 64'(s_dvalid), 64'(0));
    step(1'b0, '0, 1'b1);
    check("same_c7_valid", 64'(s_dvalid), 64'(1));
    check("same_c7_data", s_ddata, 64'h52);
    step(1'b0, '0, 1'b1);

    // Reset mid-stream with a read in flight and the buffer occupied.
    step(1'b1, 64'h61, 1'b0);
    step(1'b1, 64'h62, 1'b0);
    step(1'b1, 64'h63, 1'b0);
    enq_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_deq_valid", 64'(deq_valid), 64'(0));
    check("mid_rst_count", 64'(count), 64'(0));
    check("mid_rst_read_en", 64'(sram_read_en), 64'(0));
    check("mid_rst_enq_ready", 64'(enq_ready), 64'(1));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 64'h3C, 1'b1);
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
